// File: rtl/cpu_trace_formatter.sv
// Serializes one CPU write-back record into the ASCII trace stream read by cpu_checker:
// "^<time>@<pc>: $<grf> <= <data>#" or "^<time>@<pc>: *<addr> <= <data>#", one char per beat.
module cpu_trace_formatter #(
    parameter int SPC_COLON = 1,
    parameter int SPC_ARROW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic        in_is_reg,
    input  logic [4:0]  in_grf,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  char,
    output logic        out_last
);

    typedef enum logic [4:0] {
        S_IDLE, S_CONV, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_TYPE,
        S_REG, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
    } state_t;

    localparam logic [3:0]  CONV_STEPS  = 4'd14;
    localparam logic [13:0] TIME_MAX    = 14'd9999;
    localparam logic [3:0]  SPC_COLON_W = 4'(SPC_COLON);
    localparam logic [3:0]  SPC_ARROW_W = 4'(SPC_ARROW);

    localparam logic [7:0] CH_CARET = 8'h5E;
    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_LT    = 8'h3C;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_HASH  = 8'h23;

    state_t      state_q, state_d, next_field;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  conv_cnt_q;
    logic [15:0] bcd_q;
    logic [13:0] bin_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic        is_reg_q;
    logic [3:0]  grf_tens_q, grf_ones_q;

    logic        accept, beat, field_done;
    logic [3:0]  field_len;
    logic [2:0]  time_digits, grf_digits;
    logic [3:0]  grf_tens_d, grf_ones_d;
    logic [15:0] bcd_adj;
    logic [13:0] time_clamped;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nibble(input logic [31:0] w, input logic [2:0] idx);
        return w[{idx, 2'b00} +: 4];
    endfunction

    assign accept       = in_valid & in_ready;
    assign beat         = out_valid & out_ready;
    assign time_clamped = (in_time > TIME_MAX) ? TIME_MAX : in_time;

    // Register number is small enough to split into tens/ones directly at accept.
    always_comb begin
        grf_tens_d = 4'd0;
        grf_ones_d = 4'(in_grf);
        if (in_grf >= 5'd30) begin
            grf_tens_d = 4'd3;
            grf_ones_d = 4'(in_grf - 5'd30);
        end else if (in_grf >= 5'd20) begin
            grf_tens_d = 4'd2;
            grf_ones_d = 4'(in_grf - 5'd20);
        end else if (in_grf >= 5'd10) begin
            grf_tens_d = 4'd1;
            grf_ones_d = 4'(in_grf - 5'd10);
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        if (bcd_q[15:12] != 4'd0)     time_digits = 3'd4;
        else if (bcd_q[11:8] != 4'd0) time_digits = 3'd3;
        else if (bcd_q[7:4] != 4'd0)  time_digits = 3'd2;
        else                          time_digits = 3'd1;
    end

    assign grf_digits = (grf_tens_q != 4'd0) ? 3'd2 : 3'd1;

    // NOTE: state lives in always_ff with <= only; combinational logic uses = so
    // every reader sees the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            is_reg_q   <= 1'b0;
            grf_tens_q <= '0;
            grf_ones_q <= '0;
        end else if (accept) begin
            bin_q      <= time_clamped;
            bcd_q      <= '0;
            conv_cnt_q <= '0;
            pc_q       <= in_pc;
            addr_q     <= in_addr;
            data_q     <= in_data;
            is_reg_q   <= in_is_reg;
            grf_tens_q <= grf_tens_d;
            grf_ones_q <= grf_ones_d;
        end else if (state_q == S_CONV && conv_cnt_q != CONV_STEPS) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            conv_cnt_q     <= conv_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Character count of the field currently being emitted.
    always_comb begin
        case (state_q)
            S_TIME:               field_len = {1'b0, time_digits};
            S_REG:                field_len = {1'b0, grf_digits};
            S_PC, S_ADDR, S_DATA: field_len = 4'd8;
            S_SP1:                field_len = SPC_COLON_W;
            S_SP2, S_SP3:         field_len = SPC_ARROW_W;
            default:              field_len = 4'd1;
        endcase
    end

    assign field_done = ({1'b0, cnt_q} == field_len - 4'd1);

    always_comb begin
        case (state_q)
            S_CARET: next_field = S_TIME;
            S_TIME:  next_field = S_AT;
            S_AT:    next_field = S_PC;
            S_PC:    next_field = S_COLON;
            S_COLON: next_field = (SPC_COLON != 0) ? S_SP1 : S_TYPE;
            S_SP1:   next_field = S_TYPE;
            S_TYPE:  next_field = is_reg_q ? S_REG : S_ADDR;
            S_REG,
            S_ADDR:  next_field = (SPC_ARROW != 0) ? S_SP2 : S_LT;
            S_SP2:   next_field = S_LT;
            S_LT:    next_field = S_EQ;
            S_EQ:    next_field = (SPC_ARROW != 0) ? S_SP3 : S_DATA;
            S_SP3:   next_field = S_DATA;
            S_DATA:  next_field = S_HASH;
            default: next_field = S_IDLE;
        endcase
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_CONV;
            S_CONV: if (conv_cnt_q == CONV_STEPS) state_d = S_CARET;
            default: begin
                if (beat) begin
                    if (field_done) begin
                        cnt_d   = '0;
                        state_d = next_field;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
        endcase
    end

    assign in_ready  = reset && (state_q == S_IDLE);
    assign out_valid = (state_q != S_IDLE) && (state_q != S_CONV);
    assign out_last  = (state_q == S_HASH);

    // Output depends only on registered state, so it holds steady across stalls.
    always_comb begin
        char = 8'h00;
        case (state_q)
            S_CARET: char = CH_CARET;
            S_TIME:  char = hex_ascii(nibble({16'h0, bcd_q}, time_digits - 3'd1 - cnt_q));
            S_AT:    char = CH_AT;
            S_PC:    char = hex_ascii(nibble(pc_q, 3'd7 - cnt_q));
            S_COLON: char = CH_COLON;
            S_SP1, S_SP2, S_SP3: char = CH_SPACE;
            S_TYPE:  char = is_reg_q ? CH_DOLLAR : CH_STAR;
            S_REG:   char = hex_ascii((grf_digits == 3'd2 && cnt_q == 3'd0) ? grf_tens_q
                                                                           : grf_ones_q);
            S_ADDR:  char = hex_ascii(nibble(addr_q, 3'd7 - cnt_q));
            S_LT:    char = CH_LT;
            S_EQ:    char = CH_EQ;
            S_DATA:  char = hex_ascii(nibble(data_q, 3'd7 - cnt_q));
            S_HASH:  char = CH_HASH;
            default: char = 8'h00;
        endcase
    end

endmodule
